sar_adc: RTL

SAR_ADC -- requirements
Module: sar_adc

---
 rtl/sar_adc_pkg.sv | 18 +
 rtl/sar_dac_model.sv | 18 +
 rtl/sar_adc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared FSM state encoding and default constants for sar_adc
// Purpose: holds the conversion FSM state type and the default minimum supply.
// Contents:
//   state_t          2-bit FSM state type
//   ST_IDLE..ST_DONE state encodings
//   VDD_MIN_DEFAULT  default minimum supply voltage for operation
package sar_adc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SAMPLE  = 2'd1;
   localparam state_t ST_CONVERT = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   localparam real VDD_MIN_DEFAULT = 0.9;

endpackage

// File: rtl/sar_dac_model.sv
// rtl/sar_dac_model.sv - behavioural capacitive DAC for the SAR comparison voltage
// Purpose: converts a trial code and the reference into the real voltage the
//          held input is compared against: vdac = code * vref / 2^NBITS.
// Ports:
//   code  in   NBITS  trial code
//   vref  in   real   full-scale reference
//   vdac  out  real   comparison voltage
module sar_dac_model #(
   parameter int NBITS = 8
) (
   input  logic [NBITS-1:0] code,
   input  real              vref,
   output real              vdac
);

   assign vdac = real'(code) * vref / (2.0 ** NBITS);

endmodule

// File: rtl/sar_adc.sv
// rtl/sar_adc.sv - successive-approximation ADC behavioural model with conversion FSM
// Purpose: samples vin on request and resolves an NBITS code MSB first, one bit
//          per clock, against the reference vref.
// Optional feature: define SAR_ADC_OVR_EN to add the ovr (over-range) output.
// Ports:
//   clk    in   1      conversion clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   vdd    in   real   supply voltage
//   en     in   1      block enable
//   start  in   1      conversion request
//   vin    in   real   analog input
//   vref   in   real   full-scale reference
//   data   out  NBITS  last completed conversion code
//   done   out  1      one-cycle pulse with each new data
//   busy   out  1      high in SAMPLE and CONVERT
//   ovr    out  1      (SAR_ADC_OVR_EN only) held input was >= vref
module sar_adc
   import sar_adc_pkg::*;
#(
   parameter int  NBITS   = 8,
   parameter real VDD_MIN = VDD_MIN_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  real              vdd,
   input  logic             en,
   input  logic             start,
   input  real              vin,
   input  real              vref,
   output logic [NBITS-1:0] data,
   output logic             done,
   output logic             busy
`ifdef SAR_ADC_OVR_EN
   ,
   output logic             ovr
`endif
);

   localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [NBITS-1:0] ONE = 1;

   state_t           state;
   real              vhold;
   logic             ref_zero;
   logic [IW-1:0]    idx;
   logic [NBITS-1:0] code;
   logic [NBITS-1:0] trial;
   real              vtrial;
   logic             active;
   logic             keep;

   // An undriven or unknown enable must never count as enabled.
   assign active = (vdd > VDD_MIN) && (en === 1'b1);

   assign trial = code | (ONE << idx);
   assign keep  = (vhold >= vtrial);
   assign busy  = (state == ST_SAMPLE) || (state == ST_CONVERT);

   sar_dac_model #(
      .NBITS (NBITS)
   ) u_dac (
      .code (trial),
      .vref (vref),
      .vdac (vtrial)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         data     <= '0;
         done     <= 1'b0;
         vhold    <= 0.0;
         ref_zero <= 1'b0;
         idx      <= '0;
         code     <= '0;
`ifdef SAR_ADC_OVR_EN
         ovr      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && active) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (!active) begin
                  state <= ST_IDLE;
               end else begin
                  vhold    <= vin;
                  // A non-positive reference cannot define a scale; the code is forced to 0.
                  ref_zero <= (vref <= 0.0);
                  idx      <= IW'(NBITS - 1);
                  code     <= '0;
                  state    <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               if (!active) begin
                  state <= ST_IDLE;
               end else begin
                  if (keep) begin
                     code <= trial;
                  end
                  if (idx == '0) begin
                     state <= ST_DONE;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end
            end
            ST_DONE: begin
               data <= ref_zero ? '0 : code;
               done <= 1'b1;
`ifdef SAR_ADC_OVR_EN
               ovr  <= (vhold >= vref);
`endif
               // A held start re-enters sampling directly, so back-to-back
               // conversions repeat every NBITS+2 edges with no idle gap.
               if (start && active) begin
                  state <= ST_SAMPLE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
